// File: rtl/alu_pkg.sv
// Shared ALU definitions: Funct opcodes used by the ALU control stage and
// the sequential ALU, plus the sequential ALU state encoding.
package alu_pkg;

  localparam logic [5:0] FN_ADDU = 6'b001001;
  localparam logic [5:0] FN_SUBU = 6'b001010;
  localparam logic [5:0] FN_SLL  = 6'b100001;
  localparam logic [5:0] FN_SLLV = 6'b110101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for the two Funct codes that run through the iterative shifter.
  function automatic logic is_shift_op(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SLLV);
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative left shifter: a working register shifted one bit per step and a
// 5-bit down-counter of remaining steps.
module seq_alu_shifter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] load_val,
  input  logic [4:0]  load_cnt,
  output logic [31:0] work_next,
  output logic        cnt_last
);

  logic [31:0] work;
  logic [4:0]  cnt;

  // Value the working register takes on the next step; on the final step
  // this is the completed shift result.
  assign work_next = {work[30:0], 1'b0};

  // The step that brings the count from 1 to 0 is the completing step.
  assign cnt_last = (cnt == 5'd1);

  // Working register and count: load on accept, then one bit per SHIFT edge.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work <= '0;
      cnt  <= '0;
    end else if (load) begin
      work <= load_val;
      cnt  <= load_cnt;
    end else if (step) begin
      work <= work_next;
      cnt  <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADDU/SUBU/SLT and bit-serial SLL/SLLV.
// Results are registered and only change on a completion.
module seq_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        err
);

  state_t      state;
  logic        accept;
  logic        shift_op;
  logic [4:0]  shift_cnt;
  logic        sh_load;
  logic        sh_step;
  logic [31:0] work_next;
  logic        cnt_last;
  logic [31:0] alu_res;
  logic        alu_err;

  assign accept    = (state == ST_IDLE) && start;
  assign shift_op  = is_shift_op(Funct);
  assign shift_cnt = (Funct == FN_SLLV) ? A[4:0] : Shamt;
  assign sh_load   = accept && shift_op && (shift_cnt != 5'd0);
  assign sh_step   = (state == ST_SHIFT);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  seq_alu_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .step      (sh_step),
    .load_val  (B),
    .load_cnt  (shift_cnt),
    .work_next (work_next),
    .cnt_last  (cnt_last)
  );

  // Single-cycle arithmetic; unsupported codes yield zero with err set.
  // NOTE: defaults assigned first so no path through the case leaves an
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (Funct)
      FN_ADDU: alu_res = A + B;
      FN_SUBU: alu_res = A - B;
      FN_SLT:  alu_res = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      default: alu_err = 1'b1;
    endcase
  end

  // Control FSM: IDLE accepts, SHIFT iterates, DONE lasts one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= sh_load ? ST_SHIFT : ST_DONE;
        ST_SHIFT: if (cnt_last) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Output registers: written only when an operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result <= '0;
      Zero   <= 1'b1;
      err    <= 1'b0;
    end else if (accept && !sh_load) begin
      if (shift_op) begin
        Result <= B;
        Zero   <= (B == 32'd0);
        err    <= 1'b0;
      end else begin
        Result <= alu_res;
        Zero   <= (alu_res == 32'd0);
        err    <= alu_err;
      end
    end else if (sh_step && cnt_last) begin
      Result <= work_next;
      Zero   <= (work_next == 32'd0);
      err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
module tb_seq_alu;

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_SLL  = 6'b100001;
  localparam logic [5:0] F_SLLV = 6'b110101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_BAD  = 6'b111111;
  localparam int         LIMIT  = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Funct;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Shamt;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Zero;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_alu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Funct  (Funct),
    .A      (A),
    .B      (B),
    .Shamt  (Shamt),
    .busy   (busy),
    .done   (done),
    .Result (Result),
    .Zero   (Zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Waits for IDLE, pulses start for one edge, scrambles the operand inputs
  // after the accepting edge, then counts cycles until done (1 = next cycle).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    Funct = f; A = a; B = b; Shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Funct = F_ADDU; A = 32'hFFFF_FFFF; B = 32'hDEAD_BEEF; Shamt = 5'd7;
    lat = 1;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; Funct = '0; A = '0; B = '0; Shamt = '0;
    #12;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (Result !== 32'd0) $display("FAIL reset_result got %h exp 0", Result); else pass_cnt++;
    total_cnt++; if (Zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", Zero); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_addu();
    int lat;
    run_op(F_ADDU, 32'hFFFF_FFFF, 32'h2, 5'd0, lat);
    total_cnt++; if (lat !== 1) $display("FAIL addu_latency got %0d exp 1", lat); else pass_cnt++;
    total_cnt++; if (Result !== 32'h1) $display("FAIL addu_result got %h exp 00000001", Result); else pass_cnt++;
    total_cnt++; if (Zero !== 1'b0 || err !== 1'b0) $display("FAIL addu_flags got zero=%b err=%b exp 0 0", Zero, err); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL addu_done_width got done=%b busy=%b exp 0 0", done, busy); else pass_cnt++;
    total_cnt++; if (Result !== 32'h1) $display("FAIL addu_hold got %h exp 00000001", Result); else pass_cnt++;
  endtask

  task automatic test_subu_slt();
    int lat;
    run_op(F_SUBU, 32'd5, 32'd5, 5'd0, lat);
    total_cnt++; if (lat !== 1) $display("FAIL subu_latency got %0d exp 1", lat); else pass_cnt++;
    total_cnt++; if (Result !== 32'd0 || Zero !== 1'b1) $display("FAIL subu_result got %h zero=%b exp 0 1", Result, Zero); else pass_cnt++;
    run_op(F_SUBU, 32'd3, 32'd5, 5'd0, lat);
    total_cnt++; if (Result !== 32'hFFFF_FFFE || Zero !== 1'b0) $display("FAIL subu_wrap got %h zero=%b exp fffffffe 0", Result, Zero); else pass_cnt++;
    run_op(F_SLT, 32'hFFFF_FFFE, 32'd1, 5'd0, lat);
    total_cnt++; if (lat !== 1 || Result !== 32'd1) $display("FAIL slt_neg got lat=%0d %h exp 1 00000001", lat, Result); else pass_cnt++;
    run_op(F_SLT, 32'd1, 32'hFFFF_FFFE, 5'd0, lat);
    total_cnt++; if (Result !== 32'd0 || Zero !== 1'b1) $display("FAIL slt_pos got %h zero=%b exp 0 1", Result, Zero); else pass_cnt++;
  endtask

  task automatic test_sll();
    int lat;
    int cyc;
    int busy_low;
    int result_moved;
    run_op(F_ADDU, 32'h50, 32'h5, 5'd0, lat);
    // Manual accept so busy and Result can be watched every shift cycle.
    @(negedge clk);
    while (busy) @(negedge clk);
    Funct = F_SLL; A = 32'h0; B = 32'h1; Shamt = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Funct = F_SUBU; B = 32'hFFFF_0000; Shamt = 5'd2;
    cyc = 1; busy_low = 0; result_moved = 0;
    while (!done && cyc < LIMIT) begin
      if (!busy) busy_low++;
      if (Result !== 32'h55) result_moved++;
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++; if (cyc !== 32) $display("FAIL sll31_latency got %0d exp 32", cyc); else pass_cnt++;
    total_cnt++; if (busy_low !== 0 || busy !== 1'b1) $display("FAIL sll31_busy got low_cycles=%0d busy_at_done=%b exp 0 1", busy_low, busy); else pass_cnt++;
    total_cnt++; if (result_moved !== 0) $display("FAIL sll31_no_intermediate got %0d changed cycles exp 0", result_moved); else pass_cnt++;
    total_cnt++; if (Result !== 32'h8000_0000 || Zero !== 1'b0 || err !== 1'b0) $display("FAIL sll31_result got %h zero=%b err=%b exp 80000000 0 0", Result, Zero, err); else pass_cnt++;
    run_op(F_SLL, 32'h0, 32'h0, 5'd0, lat);
    total_cnt++; if (lat !== 1 || Result !== 32'd0 || Zero !== 1'b1) $display("FAIL sll0_result got lat=%0d %h zero=%b exp 1 0 1", lat, Result, Zero); else pass_cnt++;
  endtask

  task automatic test_sllv();
    int lat;
    run_op(F_SLLV, 32'h20, 32'h1234, 5'd9, lat);
    total_cnt++; if (lat !== 1 || Result !== 32'h1234) $display("FAIL sllv0_result got lat=%0d %h exp 1 00001234", lat, Result); else pass_cnt++;
    // Start pulsed only during DONE must be dropped.
    Funct = F_ADDU; A = 32'h1; B = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h1234) $display("FAIL sllv_busy_start_ignored got busy=%b done=%b %h exp 0 0 00001234", busy, done, Result); else pass_cnt++;
    run_op(F_SLLV, 32'h3, 32'h0F00, 5'd0, lat);
    total_cnt++; if (lat !== 4 || Result !== 32'h7800) $display("FAIL sllv3_result got lat=%0d %h exp 4 00007800", lat, Result); else pass_cnt++;
  endtask

  task automatic test_unsupported();
    int lat;
    run_op(F_BAD, 32'h1234, 32'h5678, 5'd3, lat);
    total_cnt++; if (lat !== 1 || err !== 1'b1) $display("FAIL bad_err got lat=%0d err=%b exp 1 1", lat, err); else pass_cnt++;
    total_cnt++; if (Result !== 32'd0 || Zero !== 1'b1) $display("FAIL bad_result got %h zero=%b exp 0 1", Result, Zero); else pass_cnt++;
    run_op(F_ADDU, 32'h1, 32'h1, 5'd0, lat);
    total_cnt++; if (err !== 1'b0 || Result !== 32'h2) $display("FAIL bad_then_addu got err=%b %h exp 0 00000002", err, Result); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    while (busy) @(negedge clk);
    Funct = F_ADDU; A = 32'd10; B = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b1 || Result !== 32'd30) $display("FAIL b2b_first got done=%b %h exp 1 0000001e", done, Result); else pass_cnt++;
    Funct = F_SUBU; A = 32'd100; B = 32'd1;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle_gap got busy=%b done=%b exp 0 0", busy, done); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if (done !== 1'b1 || Result !== 32'd99) $display("FAIL b2b_second got done=%b %h exp 1 00000063", done, Result); else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    int done_seen;
    run_op(F_ADDU, 32'h10, 32'h20, 5'd0, lat);
    @(negedge clk);
    while (busy) @(negedge clk);
    Funct = F_SLL; A = 32'h0; B = 32'h3; Shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL rst_mid_in_shift got busy=%b done=%b exp 1 0", busy, done); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'd0 || Zero !== 1'b1 || err !== 1'b0)
      $display("FAIL rst_mid_clear got busy=%b done=%b %h zero=%b err=%b exp 0 0 0 1 0", busy, done, Result, Zero, err);
    else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL rst_mid_no_done got %0d done cycles exp 0", done_seen); else pass_cnt++;
    run_op(F_ADDU, 32'd3, 32'd4, 5'd0, lat);
    total_cnt++; if (lat !== 1 || Result !== 32'd7 || Zero !== 1'b0) $display("FAIL rst_mid_recover got lat=%0d %h zero=%b exp 1 00000007 0", lat, Result, Zero); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_subu_slt();
    test_sll();
    test_sllv();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
